huffman_decoder: RTL

HUFFMAN_DECODER -- requirements
Module: huffman_decoder

---
 rtl/huffman_decoder.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/huffman_decoder.sv
// huffman_decoder
// Serial JPEG AC-coefficient Huffman decoder for the luminance AC table
// (ITU-T T.81 Table K.5). Bits arrive MSB-first, one per accepted cycle.
// A Huffman code is matched to a run/size byte. The following `size` raw
// bits are turned into a signed amplitude. The symbol is then presented
// on a valid/ready output.
//
// Ports
//   clk_in         clock, rising edge
//   rst_in         synchronous active-high reset
//   bit_in         serial bit (MSB-first)
//   bit_valid_in   bit_in is valid
//   bit_ready_out  decoder accepts bit_in this cycle
//   flush_in       one-cycle pulse: drop the partial symbol, clear error
//   sym_valid_out  decoded symbol present
//   sym_ready_in   consumer accepts the symbol
//   run_out        zero-run nibble
//   size_out       size-category nibble
//   amp_out        signed amplitude (0 when size_out = 0)
//   eob_out        symbol is EOB (0x00)
//   zrl_out        symbol is ZRL (0xF0)
//   error_out      sticky invalid-code flag
module huffman_decoder #(
    parameter int AMP_W = 11
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    bit_in,
    input  logic                    bit_valid_in,
    output logic                    bit_ready_out,
    input  logic                    flush_in,
    output logic                    sym_valid_out,
    input  logic                    sym_ready_in,
    output logic [3:0]              run_out,
    output logic [3:0]              size_out,
    output logic signed [AMP_W-1:0] amp_out,
    output logic                    eob_out,
    output logic                    zrl_out,
    output logic                    error_out
);

    typedef enum logic [1:0] {ST_CODE, ST_AMP, ST_OUT, ST_ERR} state_t;

    // Number of codes of each length 1..16
    localparam logic [7:0] BITS [1:16] = '{
        8'd0, 8'd2, 8'd1, 8'd3, 8'd3, 8'd2, 8'd4, 8'd3,
        8'd5, 8'd5, 8'd4, 8'd4, 8'd0, 8'd0, 8'd1, 8'd125};

    // Symbol values in canonical code order
    localparam logic [7:0] HUFFVAL [0:161] = '{
        8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11, 8'h05, 8'h12,
        8'h21, 8'h31, 8'h41, 8'h06, 8'h13, 8'h51, 8'h61, 8'h07,
        8'h22, 8'h71, 8'h14, 8'h32, 8'h81, 8'h91, 8'ha1, 8'h08,
        8'h23, 8'h42, 8'hb1, 8'hc1, 8'h15, 8'h52, 8'hd1, 8'hf0,
        8'h24, 8'h33, 8'h62, 8'h72, 8'h82, 8'h09, 8'h0a, 8'h16,
        8'h17, 8'h18, 8'h19, 8'h1a, 8'h25, 8'h26, 8'h27, 8'h28,
        8'h29, 8'h2a, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
        8'h3a, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
        8'h4a, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59,
        8'h5a, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69,
        8'h6a, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79,
        8'h7a, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89,
        8'h8a, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98,
        8'h99, 8'h9a, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7,
        8'ha8, 8'ha9, 8'haa, 8'hb2, 8'hb3, 8'hb4, 8'hb5, 8'hb6,
        8'hb7, 8'hb8, 8'hb9, 8'hba, 8'hc2, 8'hc3, 8'hc4, 8'hc5,
        8'hc6, 8'hc7, 8'hc8, 8'hc9, 8'hca, 8'hd2, 8'hd3, 8'hd4,
        8'hd5, 8'hd6, 8'hd7, 8'hd8, 8'hd9, 8'hda, 8'he1, 8'he2,
        8'he3, 8'he4, 8'he5, 8'he6, 8'he7, 8'he8, 8'he9, 8'hea,
        8'hf1, 8'hf2, 8'hf3, 8'hf4, 8'hf5, 8'hf6, 8'hf7, 8'hf8,
        8'hf9, 8'hfa};

    state_t                  state_q, state_d;
    logic [14:0]             code_q, code_d;
    logic [3:0]              len_q, len_d;
    logic [9:0]              v_q, v_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [3:0]              run_q, run_d;
    logic [3:0]              size_q, size_d;
    logic signed [AMP_W-1:0] amp_q, amp_d;
    logic                    eob_q, eob_d;
    logic                    zrl_q, zrl_d;
    logic                    error_q, error_d;

    logic [15:0]             code_shift;
    logic [4:0]              code_len;
    logic                    match;
    logic [7:0]              sym_idx;
    logic [7:0]              sym;
    logic [16:0]             lut_min;
    logic [7:0]              lut_ptr;
    logic [10:0]             v_n;
    logic [3:0]              cnt_n;
    logic [AMP_W-1:0]        v_ext;
    logic [AMP_W-1:0]        mask_ext;

    assign code_shift = {code_q, bit_in};
    assign code_len   = {1'b0, len_q} + 5'd1;
    assign v_n        = {v_q, bit_in};
    assign cnt_n      = cnt_q + 4'd1;
    assign v_ext      = AMP_W'(v_n);
    assign mask_ext   = AMP_W'((16'd1 << size_q) - 16'd1);
    assign sym        = HUFFVAL[sym_idx];

    // Canonical code walk. lut_min tracks MINCODE for each length and
    // lut_ptr tracks VALPTR, so the tables fold to constants. A code
    // of the current length matches when it is <= MAXCODE = MINCODE+BITS-1.
    always_comb begin
        match   = 1'b0;
        sym_idx = 8'd0;
        lut_min = 17'd0;
        lut_ptr = 8'd0;
        for (int l = 1; l <= 16; l++) begin
            if (code_len == 5'(l) && BITS[l] != 8'd0 &&
                {1'b0, code_shift} <= lut_min + {9'd0, BITS[l]} - 17'd1) begin
                match   = 1'b1;
                sym_idx = lut_ptr + 8'(code_shift - lut_min[15:0]);
            end
            lut_ptr = lut_ptr + BITS[l];
            lut_min = (lut_min + {9'd0, BITS[l]}) << 1;
        end
    end

    // Next-state and datapath. Flush overrides everything, including a
    // bit offered in the same cycle.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        len_d   = len_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        size_d  = size_q;
        amp_d   = amp_q;
        eob_d   = eob_q;
        zrl_d   = zrl_q;
        error_d = error_q;
        if (flush_in) begin
            state_d = ST_CODE;
            code_d  = '0;
            len_d   = '0;
            v_d     = '0;
            cnt_d   = '0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                ST_CODE: begin
                    if (bit_valid_in) begin
                        if (match) begin
                            run_d  = sym[7:4];
                            size_d = sym[3:0];
                            eob_d  = (sym == 8'h00);
                            zrl_d  = (sym == 8'hF0);
                            amp_d  = '0;
                            code_d = '0;
                            len_d  = '0;
                            v_d    = '0;
                            cnt_d  = '0;
                            state_d = (sym[3:0] != 4'd0) ? ST_AMP : ST_OUT;
                        end else if (code_len == 5'd16) begin
                            state_d = ST_ERR;
                            error_d = 1'b1;
                        end else begin
                            code_d = code_shift[14:0];
                            len_d  = code_len[3:0];
                        end
                    end
                end
                ST_AMP: begin
                    if (bit_valid_in) begin
                        v_d   = v_n[9:0];
                        cnt_d = cnt_n;
                        if (cnt_n == size_q) begin
                            // Leading 0 marks a negative value offset by 2^size-1
                            if (v_n[size_q - 4'd1])
                                amp_d = v_ext;
                            else
                                amp_d = v_ext - mask_ext;
                            state_d = ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (sym_ready_in)
                        state_d = ST_CODE;
                end
                default: ;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_CODE;
            code_q  <= '0;
            len_q   <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
            run_q   <= '0;
            size_q  <= '0;
            amp_q   <= '0;
            eob_q   <= 1'b0;
            zrl_q   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            size_q  <= size_d;
            amp_q   <= amp_d;
            eob_q   <= eob_d;
            zrl_q   <= zrl_d;
            error_q <= error_d;
        end
    end

    assign bit_ready_out = !rst_in && (state_q == ST_CODE || state_q == ST_AMP);
    assign sym_valid_out = !rst_in && (state_q == ST_OUT);
    assign run_out       = run_q;
    assign size_out      = size_q;
    assign amp_out       = amp_q;
    assign eob_out       = eob_q;
    assign zrl_out       = zrl_q;
    assign error_out     = error_q;

endmodule
